// File: rtl/des_pkg.sv
// ============================================================================
//  des_pkg
//  DES key-schedule tables (FIPS 46-3 numbering), shift table, state encoding
//  and 28-bit half rotation helpers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;

    // Entry i is the FIPS key bit that lands in CD position i+1.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Entry j is the CD bit that lands in subkey position j+1.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // SHIFTS[r-1] is the left rotation applied to reach CD_r from CD_(r-1).
    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Bit 27 of a half is its first (FIPS-lowest) bit, so a left rotate moves it to bit 0.
    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_pc2.sv
// ============================================================================
//  des_pc2
//  Combinational PC-2 selection: 56-bit CD (bit 55 = CD bit 1) to 48-bit Kn.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [48:1] subkey
);

    generate
        for (genvar j = 0; j < SUBKEY_W; j++) begin : g_pc2
            assign subkey[48-j] = cd[56-PC2[j]];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/des_key_scheduler.sv
// ============================================================================
//  des_key_scheduler
//  Streams the 16 DES round subkeys over valid/ready in encrypt or decrypt order.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module des_key_scheduler
    import des_pkg::*;
#(
    parameter int CHECK_PARITY    = 1,
    parameter int ABORT_ON_PARITY = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [64:1] key_in,
    input  logic        decrypt,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [48:1] subkey,
    output logic [3:0]  round_idx,
    output logic        done,
    output logic        parity_err
);

    state_t             r_state;
    logic               r_decrypt;
    logic [55:0]        r_cd;
    logic [55:0]        w_cd0;
    logic [55:0]        w_cd_next;
    logic [48:1]        w_subkey_next;
    logic [7:0]         w_byte_bad;
    logic               w_par_err;
    logic               w_abort;
    logic               w_last;
    logic               w_hs;
    logic [3:0]         w_idx_inc;

    generate
        for (genvar i = 0; i < 56; i++) begin : g_pc1
            assign w_cd0[55-i] = key_in[65-PC1[i]];
        end
        for (genvar k = 0; k < 8; k++) begin : g_parity
            assign w_byte_bad[k] = ~(^key_in[8*k+8 -: 8]);
        end
    endgenerate

    assign w_par_err = (CHECK_PARITY != 0) && (|w_byte_bad);
    assign w_abort   = (ABORT_ON_PARITY != 0) && w_par_err;
    assign w_hs      = subkey_valid && subkey_ready;
    assign w_last    = r_decrypt ? (round_idx == 4'd0) : (round_idx == 4'd15);
    assign w_idx_inc = round_idx + 4'd1;

    // In IDLE the next CD comes from the key; otherwise it is one round step from r_cd.
    always_comb begin
        w_cd_next = r_cd;
        if (r_state == ST_IDLE) begin
            if (decrypt)
                w_cd_next = w_cd0;
            else
                w_cd_next = {rotl28(w_cd0[55:28], SHIFTS[0]), rotl28(w_cd0[27:0], SHIFTS[0])};
        end else if (r_decrypt) begin
            w_cd_next = {rotr28(r_cd[55:28], SHIFTS[round_idx]), rotr28(r_cd[27:0], SHIFTS[round_idx])};
        end else begin
            w_cd_next = {rotl28(r_cd[55:28], SHIFTS[w_idx_inc]), rotl28(r_cd[27:0], SHIFTS[w_idx_inc])};
        end
    end

    des_pc2 u_pc2 (
        .cd     (w_cd_next),
        .subkey (w_subkey_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_decrypt    <= 1'b0;
            r_cd         <= '0;
            busy         <= 1'b0;
            subkey_valid <= 1'b0;
            subkey       <= '0;
            round_idx    <= 4'd0;
            done         <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_decrypt  <= decrypt;
                        parity_err <= w_par_err;
                        r_cd       <= w_cd_next;
                        if (w_abort) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state      <= ST_STREAM;
                            busy         <= 1'b1;
                            subkey_valid <= 1'b1;
                            subkey       <= w_subkey_next;
                            round_idx    <= decrypt ? 4'd15 : 4'd0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_state      <= ST_DONE;
                            subkey_valid <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            r_cd      <= w_cd_next;
                            subkey    <= w_subkey_next;
                            round_idx <= r_decrypt ? round_idx - 4'd1 : w_idx_inc;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_des_key_scheduler.sv
// ============================================================================
//  tb_des_key_scheduler
//  Self-checking bench: bit-level DES key-schedule model vs. the scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_des_key_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, decrypt, subkey_ready;
    logic [63:0] key_in;
    logic        busy, subkey_valid, done, parity_err;
    logic [47:0] subkey;
    logic [3:0]  round_idx;

    logic        start_a, decrypt_a, subkey_ready_a;
    logic [63:0] key_in_a;
    logic        busy_a, subkey_valid_a, done_a, parity_err_a;
    logic [47:0] subkey_a;
    logic [3:0]  round_idx_a;

    des_key_scheduler #(.CHECK_PARITY(1), .ABORT_ON_PARITY(0)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .decrypt(decrypt),
        .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .subkey(subkey), .round_idx(round_idx), .done(done), .parity_err(parity_err)
    );

    des_key_scheduler #(.CHECK_PARITY(1), .ABORT_ON_PARITY(1)) dut_abort (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_in_a), .decrypt(decrypt_a),
        .busy(busy_a), .subkey_valid(subkey_valid_a), .subkey_ready(subkey_ready_a),
        .subkey(subkey_a), .round_idx(round_idx_a), .done(done_a), .parity_err(parity_err_a)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                       60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                       29,21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SH_T  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] ref_k   [16];
    logic [47:0] cap     [16];
    logic [47:0] enc_cap [16];

    // Straight FIPS description: bit arrays numbered 1..64, rotate C and D one place at a time.
    task automatic model(input logic [63:0] key);
        bit kb [1:64];
        bit c [28];
        bit d [28];
        bit tc, td;
        int p;
        for (int n = 1; n <= 64; n++) kb[n] = key[64-n];
        for (int i = 0; i < 28; i++) begin
            c[i] = kb[PC1_T[i]];
            d[i] = kb[PC1_T[i+28]];
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SH_T[r]; s++) begin
                tc = c[0];
                td = d[0];
                for (int i = 0; i < 27; i++) begin
                    c[i] = c[i+1];
                    d[i] = d[i+1];
                end
                c[27] = tc;
                d[27] = td;
            end
            for (int j = 0; j < 48; j++) begin
                p = PC2_T[j];
                ref_k[r][47-j] = (p <= 28) ? c[p-1] : d[p-29];
            end
        end
    endtask

    function automatic logic ref_parity(input logic [63:0] k);
        for (int b = 0; b < 8; b++)
            if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_stream(input logic [63:0] key, input bit dec, input bit rnd,
                              input bit inject, input string tag);
        int          hs = 0;
        int          cyc = 0;
        int          exp_r;
        bit          stalled = 0;
        bit          injected = 0;
        logic [47:0] st_sub;
        logic [3:0]  st_idx;
        model(key);
        @(negedge clk);
        key_in = key; decrypt = dec; start = 1'b1; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key_in = {$urandom, $urandom};
        decrypt = ~dec;
        check({tag, "_valid_latency"}, {63'd0, subkey_valid}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        check({tag, "_parity_err"}, {63'd0, parity_err}, {63'd0, ref_parity(key)});
        while (hs < 16 && cyc < 300) begin
            if (rnd) subkey_ready = 1'($urandom_range(0, 1));
            if (inject && hs == 5 && !injected) begin
                start = 1'b1; key_in = ~key; decrypt = ~dec; injected = 1;
            end else begin
                start = 1'b0;
            end
            if (stalled) begin
                check({tag, "_stall_hold"}, {12'd0, round_idx, subkey}, {12'd0, st_idx, st_sub});
                stalled = 0;
            end
            if (!rnd) check({tag, "_no_bubble"}, {63'd0, subkey_valid}, 64'd1);
            exp_r = dec ? 15 - hs : hs;
            if (subkey_valid && subkey_ready) begin
                check({tag, "_subkey"}, {16'd0, subkey}, {16'd0, ref_k[exp_r]});
                check({tag, "_round_idx"}, {60'd0, round_idx}, 64'(exp_r));
                cap[hs] = subkey;
                hs++;
            end else if (subkey_valid) begin
                stalled = 1;
                st_sub = subkey;
                st_idx = round_idx;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_handshakes"}, 64'(hs), 64'd16);
        if (!rnd) check({tag, "_cycles"}, 64'(cyc), 64'd16);
        check({tag, "_end_vbd"}, {61'd0, subkey_valid, busy, done}, {61'd0, 3'b001});
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        subkey_ready = 1'b1;
    endtask

    initial begin
        int   guard;
        logic [63:0] k;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1; key_in = '0;
        start_a = 1'b0; decrypt_a = 1'b0; subkey_ready_a = 1'b1; key_in_a = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {8'd0, busy, subkey_valid, done, parity_err, round_idx, subkey},
              64'd0);
        rst = 1'b0;

        run_stream(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, "enc_known");
        check("enc_k1", {16'd0, cap[0]}, {16'd0, 48'h1B02EFFC7072});
        check("enc_k16", {16'd0, cap[15]}, {16'd0, 48'hCB3D8B0E17F5});
        for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];

        run_stream(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, "dec_known");
        check("dec_first", {16'd0, cap[0]}, {16'd0, 48'hCB3D8B0E17F5});
        check("dec_last", {16'd0, cap[15]}, {16'd0, 48'h1B02EFFC7072});
        for (int i = 0; i < 16; i++) check("dec_reverse", {16'd0, cap[i]}, {16'd0, enc_cap[15-i]});

        run_stream(64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0, "backpressure");
        run_stream(64'h133457799BBCDFF0, 1'b0, 1'b1, 1'b0, "bad_parity");
        for (int i = 0; i < 16; i++) check("bad_parity_same", {16'd0, cap[i]}, {16'd0, enc_cap[i]});
        run_stream(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b1, "start_ignored");

        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom};
            run_stream(k, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), "random");
        end

        // Asynchronous reset in the middle of a stream.
        @(negedge clk);
        key_in = 64'h133457799BBCDFF1; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (round_idx != 4'd7 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("reach_round7", {60'd0, round_idx}, 64'd7);
        #2 rst = 1'b1;
        #1 check("async_reset", {8'd0, busy, subkey_valid, done, parity_err, round_idx, subkey},
                 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_stream(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, "post_reset");
        check("post_reset_k1", {16'd0, cap[0]}, {16'd0, 48'h1B02EFFC7072});

        // Abort-on-parity instance.
        @(negedge clk);
        key_in_a = 64'h133457799BBCDFF0; decrypt_a = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("abort_vbdp", {60'd0, subkey_valid_a, busy_a, done_a, parity_err_a},
              {60'd0, 4'b0011});
        @(negedge clk);
        check("abort_after", {62'd0, subkey_valid_a, done_a}, 64'd0);
        key_in_a = 64'h133457799BBCDFF1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("abort_good_valid", {63'd0, subkey_valid_a}, 64'd1);
        check("abort_good_k1", {16'd0, subkey_a}, {16'd0, 48'h1B02EFFC7072});
        check("abort_good_parity", {63'd0, parity_err_a}, 64'd0);
        guard = 0;
        while (!done_a && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("abort_good_done", {63'd0, done_a}, 64'd1);
        check("abort_good_cycles", 64'(guard), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/des_key_scheduler.md
Name: des_key_scheduler

Overview:
- Sequential DES/3DES key-schedule engine. Accepts one 64-bit key and applies PC-1, then streams the 16 round subkeys through a valid/ready handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key register file and the round datapath, replacing per-round combinational subkey logic.
- Optionally checks odd byte parity on the key.

Parameters:
- CHECK_PARITY, 1: 1 = evaluate odd parity per key byte; 0 = parity_err tied 0.
- ABORT_ON_PARITY, 0: 1 = on parity error emit no subkeys, pulse done only (valid only when CHECK_PARITY=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request new schedule; sampled only in IDLE
- key_in  in  64  key; key_in[64] = FIPS bit 1 (hex MSB), key_in[1] = FIPS bit 64
- decrypt  in  1  0 = K1..K16, 1 = K16..K1; latched with start
- busy  out  1  high from accepted start until done
- subkey_valid  out  1  subkey/round_idx valid
- subkey_ready  in  1  consumer accepts the current subkey
- subkey  out  48  round key; subkey[48] = FIPS bit 1 of Kn
- round_idx  out  4  round number minus 1 (0 = K1, 15 = K16)
- done  out  1  one-cycle pulse after the last subkey handshake (or abort)
- parity_err  out  1  registered parity result; held until the next accepted start

Behaviour:
- Reset (async, any time including mid-schedule): state = IDLE.
  - busy, subkey_valid, done, parity_err = 0.
  - subkey, round_idx, C/D registers = 0.
  - No partial stream resumes after reset.
- States: IDLE, STREAM, DONE.
- IDLE, start = 1:
  - Compute CD0 = PC-1(key_in), split into C (28 bits) and D (28 bits).
  - Latch decrypt. Register parity_err.
  - Go to STREAM next cycle with busy = 1.
  - start while busy is ignored; key_in and decrypt are not re-sampled.
- Shift table s[r], r = 1..16:
  - 1 for r = 1, 2, 9, 16.
  - 2 otherwise.
  - Total rotation is 28, so CD16 == CD0.
- Encrypt:
  - On accept, register CD1 = rotl(CD0, s[1]) on each half, subkey = PC-2(CD1), round_idx = 0.
  - On each handshake (subkey_valid & subkey_ready) at round r < 16: CD <= rotl(CD, s[r+1]), subkey <= PC-2(next CD), round_idx++.
- Decrypt:
  - On accept, CD register = CD0, subkey = PC-2(CD0) = K16, round_idx = 15.
  - On handshake at round r > 1: CD <= rotr(CD, s[r]), subkey <= PC-2(next CD), round_idx--.
- Latency: subkey_valid rises exactly 1 cycle after start is accepted.
- Handshake rules:
  - Zero-bubble: with ready held high, one subkey per cycle, 16 consecutive cycles.
  - subkey and round_idx hold stable while valid & !ready.
- Last subkey handshake (round_idx 15 in encrypt, 0 in decrypt):
  - Next cycle: subkey_valid = 0, state = DONE, done = 1 for one cycle, busy = 0.
  - Then IDLE.
  - Start is not accepted in the DONE cycle.
- Abort (ABORT_ON_PARITY = 1 and parity error):
  - Go from IDLE directly to DONE.
  - parity_err = 1, done pulses 1 cycle after accept, subkey_valid never asserts.
- Parity rule: each byte key_in[8k:8k-7] must contain an odd number of ones; any failing byte sets parity_err.
- Parity bits (FIPS 8, 16, .., 64) never affect subkeys.
- Rotations are within each 28-bit half; no carry between C and D.

Decomposition:
- Package des_pkg holds:
  - PC-1 index table (56 entries) and PC-2 index table (48 entries), FIPS 46-3 numbering.
  - Shift table s[1..16].
  - State enum.
  - Width constants KEY_W = 64, CD_W = 28, SUBKEY_W = 48.
- Sub-module des_pc2: purely combinational, 56-bit CD in, 48-bit subkey out. Instantiated once on the next-CD value feeding the subkey register.

Test Plan:
- Reset, then encrypt with key_in = 64'h133457799BBCDFF1 and ready held high -> valid 1 cycle after start; round 0 subkey = 48'h1B02EFFC7072; round 15 = 48'hCB3D8B0E17F5; 16 consecutive valid cycles; done pulse next cycle; parity_err = 0.
- Same key, decrypt = 1 -> first subkey 48'hCB3D8B0E17F5 with round_idx 15; last subkey 48'h1B02EFFC7072 with round_idx 0; sequence is the exact reverse of the encrypt capture.
- Backpressure: ready toggled pseudo-randomly -> subkey and round_idx stable while stalled; no round skipped or duplicated; exactly 16 handshakes.
- key_in = 64'h133457799BBCDFF0 (bad parity, byte 0xF0) with ABORT_ON_PARITY = 0 -> parity_err = 1; subkeys identical to the 0x...F1 run. With ABORT_ON_PARITY = 1 -> no valid; done 1 cycle after start.
- start pulsed with a different key during STREAM -> ignored; original stream completes unchanged.
- rst asserted asynchronously mid-stream at round 7 -> all outputs 0 immediately; a new start afterwards yields round 0 = 48'h1B02EFFC7072.
